// File: rtl/serial_word_receiver_pkg.sv
// Shared definitions for the serial word receiver and its capture register.
// The default word width is the same one the upstream pulse_generator uses.
package serial_word_receiver_pkg;

  localparam int WORD_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } rxState_e;

  // Index of the last bit of a word, sized to the bit counter
  function automatic int lastBitIndex(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/serial_word_receiver_shift_capture.sv
// Shift register that assembles a serial word in either bit order.
// The clear input restarts the word: old contents are dropped while the
// current bit is shifted in as the first bit of the new word.
module shift_capture #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             shift_en_i,
  input  logic             clear_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] word_o
);

  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;
  logic [WIDTH-1:0] base;

  // Pick the register contents the new bit is shifted into, then shift in the chosen direction
  always_comb begin
    base   = clear_i ? '0 : word_q;
    word_d = word_q;
    if (shift_en_i) begin
      if (MSB_FIRST) begin
        word_d = {base[WIDTH-2:0], bit_i};
      end else begin
        word_d = {bit_i, base[WIDTH-1:1]};
      end
    end
  end

  // Word register with asynchronous clear
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver fed by pulse_generator.
// Rebuilds WIDTH-bit words from a 1-bit stream framed by frame_start, flags
// words equal to PATTERN and counts completed words. An early frame_start
// aborts the partial word and restarts framing on the current bit.
module serial_word_receiver
  import serial_word_receiver_pkg::*;
#(
  parameter int               WIDTH     = WORD_WIDTH,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] PATTERN   = 16'hA554,
  parameter int               CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             frame_start,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             match,
  output logic             frame_error,
  output logic [CNT_W-1:0] word_count,
  output logic             busy
);

  localparam int BCW = $clog2(WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(lastBitIndex(WIDTH));
  localparam logic MATCH_RESET = (PATTERN == '0);

  rxState_e         state_q, state_d;
  logic [BCW-1:0]   bitCnt_q, bitCnt_d;
  logic [WIDTH-1:0] wordOut_q, wordOut_d;
  logic             valid_q, valid_d;
  logic             match_q, match_d;
  logic             frameErr_q, frameErr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             shiftEn;
  logic             clearWord;
  logic [WIDTH-1:0] assembled;

  shift_capture #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_capture (
    .clock_i    (clock),
    .reset_i    (reset),
    .shift_en_i (shiftEn),
    .clear_i    (clearWord),
    .bit_i      (serial_in),
    .word_o     (assembled)
  );

  // Framing FSM: decides when to shift, when a word is complete and what the outputs become
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    wordOut_d  = wordOut_q;
    valid_d    = 1'b0;
    match_d    = match_q;
    frameErr_d = 1'b0;
    count_d    = count_q;
    shiftEn    = 1'b0;
    clearWord  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          shiftEn   = 1'b1;
          clearWord = 1'b1;
          bitCnt_d  = BCW'(1);
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shiftEn = 1'b1;
        if (frame_start) begin
          clearWord  = 1'b1;
          bitCnt_d   = BCW'(1);
          frameErr_d = 1'b1;
        end else if (bitCnt_q == LAST_BIT) begin
          bitCnt_d = '0;
          state_d  = ST_DONE;
        end else begin
          bitCnt_d = bitCnt_q + BCW'(1);
        end
      end
      ST_DONE: begin
        wordOut_d = assembled;
        valid_d   = 1'b1;
        match_d   = (assembled == PATTERN);
        count_d   = count_q + CNT_W'(1);
        if (frame_start) begin
          shiftEn   = 1'b1;
          clearWord = 1'b1;
          bitCnt_d  = BCW'(1);
          state_d   = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        bitCnt_d = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State, bit counter and registered outputs, all cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bitCnt_q   <= '0;
      wordOut_q  <= '0;
      valid_q    <= 1'b0;
      match_q    <= MATCH_RESET;
      frameErr_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      wordOut_q  <= wordOut_d;
      valid_q    <= valid_d;
      match_q    <= match_d;
      frameErr_q <= frameErr_d;
      count_q    <= count_d;
    end
  end

  assign word_out    = wordOut_q;
  assign word_valid  = valid_q;
  assign match       = match_q;
  assign frame_error = frameErr_q;
  assign word_count  = count_q;
  assign busy        = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed testbench for serial_word_receiver.
// The bench serialises words itself (standing in for pulse_generator) and
// drives four receivers from the same stream: the default build, an
// LSB-first build, a 2-bit word counter build and a PATTERN=0 build.
module tb_serial_word_receiver;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic serialIn = 1'b0;
  logic frameStart = 1'b0;

  logic [15:0] wordA, wordB, wordC, wordD;
  logic        validA, validB, validC, validD;
  logic        matchA, matchB, matchC, matchD;
  logic        errA, errB, errC, errD;
  logic [7:0]  countA, countB, countD;
  logic [1:0]  countC;
  logic        busyA, busyB, busyC, busyD;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int startCyc = 0;

  int          validCycA[$];
  logic [15:0] wordLogA[$];
  logic        matchLogA[$];
  logic [7:0]  countLogA[$];
  int          errCycA[$];
  int          validCntB = 0;
  logic [15:0] lastWordB = '0;
  logic [1:0]  countLogC[$];
  logic        matchLogC[$];

  serial_word_receiver dutA (
    .clock(clock), .reset(reset), .serial_in(serialIn), .frame_start(frameStart),
    .word_out(wordA), .word_valid(validA), .match(matchA), .frame_error(errA),
    .word_count(countA), .busy(busyA)
  );

  serial_word_receiver #(.MSB_FIRST(1'b0)) dutB (
    .clock(clock), .reset(reset), .serial_in(serialIn), .frame_start(frameStart),
    .word_out(wordB), .word_valid(validB), .match(matchB), .frame_error(errB),
    .word_count(countB), .busy(busyB)
  );

  serial_word_receiver #(.CNT_W(2)) dutC (
    .clock(clock), .reset(reset), .serial_in(serialIn), .frame_start(frameStart),
    .word_out(wordC), .word_valid(validC), .match(matchC), .frame_error(errC),
    .word_count(countC), .busy(busyC)
  );

  serial_word_receiver #(.PATTERN(16'h0000)) dutD (
    .clock(clock), .reset(reset), .serial_in(serialIn), .frame_start(frameStart),
    .word_out(wordD), .word_valid(validD), .match(matchD), .frame_error(errD),
    .word_count(countD), .busy(busyD)
  );

  always #5 clock = ~clock;

  // Edge counter and output logger; samples 1 ns after each rising edge
  always @(posedge clock) begin
    cyc++;
    #1;
    if (validA) begin
      validCycA.push_back(cyc);
      wordLogA.push_back(wordA);
      matchLogA.push_back(matchA);
      countLogA.push_back(countA);
    end
    if (errA) errCycA.push_back(cyc);
    if (validB) begin
      validCntB++;
      lastWordB = wordB;
    end
    if (validC) begin
      countLogC.push_back(countC);
      matchLogC.push_back(matchC);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Wait for a rising edge, then settle 2 ns after it (after the logger)
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic clearLogs();
    validCycA.delete();
    wordLogA.delete();
    matchLogA.delete();
    countLogA.delete();
    errCycA.delete();
    validCntB = 0;
    lastWordB = '0;
    countLogC.delete();
    matchLogC.delete();
  endtask

  task automatic resetDut();
    reset = 1'b1;
    frameStart = 1'b0;
    serialIn = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic idle(input int n);
    serialIn = 1'bx;
    frameStart = 1'b0;
    repeat (n) tick();
  endtask

  // Serialise the first nBits of a word, frame_start on the first bit
  task automatic applyStimulus(input logic [15:0] w, input int nBits, input bit lsbFirst);
    for (int i = 0; i < nBits; i++) begin
      serialIn = lsbFirst ? w[i] : w[15 - i];
      frameStart = (i == 0);
      tick();
      if (i == 0) startCyc = cyc;
    end
    frameStart = 1'b0;
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int abortCyc;
    logic [1:0] expCount [5];
    expCount = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Test 1: reset values, X in IDLE, reset mid-word
    $display("[TB] test 1: reset behaviour");
    resetDut();
    clearLogs();
    checkOutput("t1_wordOut", 32'(wordA), 32'h0);
    checkOutput("t1_valid", 32'(validA), 32'h0);
    checkOutput("t1_match", 32'(matchA), 32'h0);
    checkOutput("t1_matchPattern0", 32'(matchD), 32'h1);
    checkOutput("t1_frameErr", 32'(errA), 32'h0);
    checkOutput("t1_count", 32'(countA), 32'h0);
    checkOutput("t1_busy", 32'(busyA), 32'h0);
    idle(10);
    checkOutput("t1_idleX_pulses", 32'(validCycA.size()), 32'h0);
    checkOutput("t1_idleX_busy", 32'(busyA), 32'h0);
    applyStimulus(16'hA554, 5, 1'b0);
    checkOutput("t1_busyMidWord", 32'(busyA), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("t1_asyncBusy", 32'(busyA), 32'h0);
    checkOutput("t1_asyncCount", 32'(countA), 32'h0);
    tick();
    reset = 1'b0;
    idle(20);
    checkOutput("t1_noPulseAfterAbortReset", 32'(validCycA.size()), 32'h0);
    checkOutput("t1_wordAfterReset", 32'(wordA), 32'h0);

    // Test 2: single frame A554 straight after the reset test
    $display("[TB] test 2: single frame");
    clearLogs();
    applyStimulus(16'hA554, 16, 1'b0);
    checkOutput("t2_validBeforeDone", 32'(validA), 32'h0);
    idle(1);
    checkOutput("t2_valid", 32'(validA), 32'h1);
    checkOutput("t2_word", 32'(wordA), 32'hA554);
    checkOutput("t2_match", 32'(matchA), 32'h1);
    checkOutput("t2_count", 32'(countA), 32'h1);
    checkOutput("t2_pulses", 32'(validCycA.size()), 32'h1);
    if (validCycA.size() > 0)
      checkOutput("t2_latencyEdges", 32'(validCycA[0] - startCyc + 1), 32'd17);
    idle(1);
    checkOutput("t2_validOneCycle", 32'(validA), 32'h0);
    checkOutput("t2_wordHeld", 32'(wordA), 32'hA554);

    // Test 3: back-to-back frames, second frame_start in the DONE cycle
    $display("[TB] test 3: back-to-back frames");
    resetDut();
    clearLogs();
    applyStimulus(16'h5AA5, 16, 1'b0);
    applyStimulus(16'hFFFF, 16, 1'b0);
    idle(3);
    checkOutput("t3_pulses", 32'(validCycA.size()), 32'd2);
    if (validCycA.size() >= 2) begin
      checkOutput("t3_word0", 32'(wordLogA[0]), 32'h5AA5);
      checkOutput("t3_word1", 32'(wordLogA[1]), 32'hFFFF);
      checkOutput("t3_match0", 32'(matchLogA[0]), 32'h0);
      checkOutput("t3_match1", 32'(matchLogA[1]), 32'h0);
      // Second word's bit 0 is sampled on the DONE edge, so pulses sit WIDTH edges apart
      checkOutput("t3_gap", 32'(validCycA[1] - validCycA[0]), 32'd16);
    end
    checkOutput("t3_count", 32'(countA), 32'd2);
    checkOutput("t3_frameErr", 32'(errCycA.size()), 32'h0);

    // Test 4: abort after 9 bits, then a full 0001
    $display("[TB] test 4: aborted frame");
    resetDut();
    clearLogs();
    applyStimulus(16'hFFFF, 9, 1'b0);
    applyStimulus(16'h0001, 16, 1'b0);
    abortCyc = startCyc;
    idle(3);
    checkOutput("t4_errPulses", 32'(errCycA.size()), 32'h1);
    if (errCycA.size() > 0)
      checkOutput("t4_errCycle", 32'(errCycA[0]), 32'(abortCyc));
    checkOutput("t4_errCleared", 32'(errA), 32'h0);
    checkOutput("t4_pulses", 32'(validCycA.size()), 32'h1);
    checkOutput("t4_word", 32'(wordA), 32'h0001);
    checkOutput("t4_count", 32'(countA), 32'h1);

    // Test 5: LSB-first build receiving 8000 sent LSB first
    $display("[TB] test 5: LSB first");
    resetDut();
    clearLogs();
    applyStimulus(16'h8000, 16, 1'b1);
    idle(2);
    checkOutput("t5_pulses", 32'(validCntB), 32'h1);
    checkOutput("t5_word", 32'(lastWordB), 32'h8000);
    checkOutput("t5_wordOut", 32'(wordB), 32'h8000);

    // Test 6: 2-bit counter wraps over five A554 frames; each must match
    $display("[TB] test 6: counter wrap and loop-back match");
    resetDut();
    clearLogs();
    repeat (5) begin
      applyStimulus(16'hA554, 16, 1'b0);
      idle(2);
    end
    checkOutput("t6_pulses", 32'(countLogC.size()), 32'd5);
    if (countLogC.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        checkOutput($sformatf("t6_count%0d", i), 32'(countLogC[i]), 32'(expCount[i]));
        checkOutput($sformatf("t6_match%0d", i), 32'(matchLogC[i]), 32'h1);
      end
    end
    checkOutput("t6_finalCount", 32'(countC), 32'h1);
    checkOutput("t6_word", 32'(wordC), 32'hA554);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
